// File: rtl/core_control_q_if.sv
// Job-submission, memory-controller and processing-unit signals of the core control block.
// The controller is the slave side; whatever drives jobs and completion events is the master.
interface core_control_q_if #(
  parameter int OP_W  = 3,
  parameter int LEN_W = 6
);

  logic [OP_W-1:0]  ctrl_instruction;
  logic [LEN_W-1:0] ctrl_data_in_size;
  logic             ctrl_valid_inst;
  logic             ctrl_valid_data;
  logic             ctrl_ready;
  logic             ctrl_error_clr;
  logic             mc_done;
  logic             mc_data_done;
  logic             procc_done;
  logic [LEN_W-1:0] mc_data_length;
  logic [2:0]       ctrl_data_condition;
  logic [OP_W-1:0]  procc_instruction;
  logic             procc_start;
  logic             ctrl_busy;
  logic             ctrl_job_done;
  logic             ctrl_error;
  logic [7:0]       ctrl_pass_count;

  modport master (
    output ctrl_instruction, ctrl_data_in_size, ctrl_valid_inst, ctrl_valid_data,
           ctrl_error_clr, mc_done, mc_data_done, procc_done,
    input  ctrl_ready, mc_data_length, ctrl_data_condition, procc_instruction,
           procc_start, ctrl_busy, ctrl_job_done, ctrl_error, ctrl_pass_count
  );

  modport slave (
    input  ctrl_instruction, ctrl_data_in_size, ctrl_valid_inst, ctrl_valid_data,
           ctrl_error_clr, mc_done, mc_data_done, procc_done,
    output ctrl_ready, mc_data_length, ctrl_data_condition, procc_instruction,
           procc_start, ctrl_busy, ctrl_job_done, ctrl_error, ctrl_pass_count
  );

endinterface

// File: rtl/core_control_q.sv
// Queued core control FSM: buffers jobs in a small FIFO and sequences store, transfer and
// processing passes for each, with a per-state watchdog, a pass limit and a sticky error state.
module core_control_q #(
  parameter int OP_W       = 3,
  parameter int LEN_W      = 6,
  parameter int DEPTH_LOG2 = 2,
  parameter int TIMEOUT    = 255,
  parameter int MAX_PASSES = 15
) (
  input logic           ctrl_clk,
  input logic           ctrl_reset_n,
  core_control_q_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ENT_W = OP_W + LEN_W;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int CNT_W = DEPTH_LOG2 + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STORE = 3'd1;
  localparam logic [2:0] S_TRANS = 3'd2;
  localparam logic [2:0] S_PROC  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [2:0] COND_NONE  = 3'b000;
  localparam logic [2:0] COND_INPUT = 3'b100;
  localparam logic [2:0] COND_MEM   = 3'b010;
  localparam logic [2:0] COND_REG   = 3'b001;

  logic [ENT_W-1:0]      fifo_mem [DEPTH];
  logic [ENT_W-1:0]      head;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;
  logic                  ready_q;
  logic                  push;
  logic                  pop;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [WD_W-1:0]       wdog;
  logic                  wdog_expired;
  logic                  pass_below_max;
  logic                  enter_error;

  logic [LEN_W-1:0]      len_q;
  logic [OP_W-1:0]       op_q;
  logic [2:0]            cond_q;
  logic                  start_q;
  logic                  done_q;
  logic                  err_q;
  logic [7:0]            pass_q;

  // A job only leaves the FIFO from IDLE, and pop looks at the pre-edge count, so a job
  // pushed on one edge cannot be popped before the next.
  assign push      = bus.ctrl_valid_inst & bus.ctrl_valid_data & ready_q;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  assign head      = fifo_mem[rd_ptr];

  assign wdog_expired   = (wdog == WD_W'(TIMEOUT - 1));
  assign pass_below_max = (pass_q < 8'(MAX_PASSES));
  assign enter_error    = (state_nxt == S_ERROR) && (state != S_ERROR);

  always_ff @(posedge ctrl_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.ctrl_instruction, bus.ctrl_data_in_size};
    end
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count   <= count_nxt;
      ready_q <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  // An advancing event always beats a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_STORE;
      S_STORE: begin
        if (bus.mc_done)       state_nxt = S_TRANS;
        else if (wdog_expired) state_nxt = S_ERROR;
      end
      S_TRANS: begin
        if (bus.mc_done)       state_nxt = S_PROC;
        else if (wdog_expired) state_nxt = S_ERROR;
      end
      S_PROC: begin
        if (bus.mc_data_done)    state_nxt = S_IDLE;
        else if (bus.procc_done) state_nxt = pass_below_max ? S_TRANS : S_ERROR;
        else if (wdog_expired)   state_nxt = S_ERROR;
      end
      S_ERROR: if (bus.ctrl_error_clr) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state <= S_IDLE;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        wdog <= '0;
      end else if (state == S_STORE || state == S_TRANS || state == S_PROC) begin
        wdog <= wdog + WD_W'(1);
      end else begin
        wdog <= '0;
      end
    end
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      len_q   <= '0;
      op_q    <= '0;
      cond_q  <= COND_NONE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pass_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (enter_error) begin
        err_q   <= 1'b1;
        cond_q  <= COND_NONE;
        start_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (pop) begin
              len_q  <= head[LEN_W-1:0];
              op_q   <= head[ENT_W-1:LEN_W];
              cond_q <= COND_INPUT;
              pass_q <= '0;
            end
          end
          S_STORE: if (bus.mc_done) cond_q <= COND_MEM;
          S_TRANS: begin
            if (bus.mc_done) begin
              start_q <= 1'b1;
              cond_q  <= COND_REG;
              pass_q  <= pass_q + 8'd1;
            end
          end
          S_PROC: begin
            if (bus.mc_data_done) begin
              cond_q  <= COND_NONE;
              start_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (bus.procc_done) begin
              cond_q  <= COND_MEM;
              start_q <= 1'b0;
            end
          end
          S_ERROR: if (bus.ctrl_error_clr) err_q <= 1'b0;
          default: begin
            cond_q  <= COND_NONE;
            start_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ctrl_ready          = ready_q;
  assign bus.mc_data_length      = len_q;
  assign bus.procc_instruction   = op_q;
  assign bus.ctrl_data_condition = cond_q;
  assign bus.procc_start         = start_q;
  assign bus.ctrl_busy           = (state != S_IDLE);
  assign bus.ctrl_job_done       = done_q;
  assign bus.ctrl_error          = err_q;
  assign bus.ctrl_pass_count     = pass_q;

endmodule

// File: tb/tb_core_control_q.sv
// Scoreboard bench for core_control_q: a reactive responder plays memory controller and
// processing unit from a per-job plan, and a monitor checks each job's outcome.
module tb_core_control_q;

  localparam int OP_W       = 3;
  localparam int LEN_W      = 6;
  localparam int DEPTH_LOG2 = 2;
  localparam int TIMEOUT    = 20;
  localparam int MAX_PASSES = 4;

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [LEN_W-1:0] len;
    int               extra;
    int               store_delay;
    bit               stall;
  } plan_t;

  typedef struct {
    bit               is_err;
    logic [OP_W-1:0]  op;
    logic [LEN_W-1:0] len;
    int               passes;
  } exp_t;

  logic ctrl_clk     = 1'b0;
  logic ctrl_reset_n = 1'b0;

  plan_t plan_q[$];
  exp_t  sb_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  core_control_q_if #(.OP_W(OP_W), .LEN_W(LEN_W)) bus ();

  core_control_q #(
    .OP_W(OP_W), .LEN_W(LEN_W), .DEPTH_LOG2(DEPTH_LOG2),
    .TIMEOUT(TIMEOUT), .MAX_PASSES(MAX_PASSES)
  ) dut (
    .ctrl_clk(ctrl_clk),
    .ctrl_reset_n(ctrl_reset_n),
    .bus(bus.slave)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pushes one job and, on the edge that accepts it, records both the responder plan and
  // the outcome the rules predict: error on stall or pass overflow, otherwise extra+1 passes.
  task automatic applyStimulus(input int op, input int len, input int extra,
                               input int store_delay, input bit stall, input bit noisy);
    plan_t p;
    exp_t  e;
    int    guard = 0;
    if (noisy && $urandom_range(0, 3) == 0) begin
      @(negedge ctrl_clk);
      bus.ctrl_instruction  = OP_W'($urandom_range(0, 7));
      bus.ctrl_valid_inst   = 1'($urandom_range(0, 1));
      bus.ctrl_valid_data   = ~bus.ctrl_valid_inst;
    end
    forever begin
      @(negedge ctrl_clk);
      if (bus.ctrl_ready) break;
      bus.ctrl_valid_inst = 1'b0;
      bus.ctrl_valid_data = 1'b0;
      guard++;
      if (guard > 2000) begin
        checkOutput("push_ready_wait", 32'(bus.ctrl_ready), 32'd1);
        return;
      end
    end
    bus.ctrl_instruction  = OP_W'(op);
    bus.ctrl_data_in_size = LEN_W'(len);
    bus.ctrl_valid_inst   = 1'b1;
    bus.ctrl_valid_data   = 1'b1;
    @(posedge ctrl_clk);
    p.op = OP_W'(op); p.len = LEN_W'(len); p.extra = extra;
    p.store_delay = store_delay; p.stall = stall;
    e.op = OP_W'(op); e.len = LEN_W'(len);
    if (stall) begin
      e.is_err = 1'b1; e.passes = 0;
    end else if (extra >= MAX_PASSES) begin
      e.is_err = 1'b1; e.passes = MAX_PASSES;
    end else begin
      e.is_err = 1'b0; e.passes = extra + 1;
    end
    plan_q.push_back(p);
    sb_q.push_back(e);
    #1;
    bus.ctrl_valid_inst = 1'b0;
    bus.ctrl_valid_data = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int g = 0;
    while ((sb_q.size() != 0 || bus.ctrl_busy) && g < limit) begin
      @(negedge ctrl_clk);
      g++;
    end
    checkOutput("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  // Responder: reacts to the condition code like the surrounding units would, with random
  // latencies and occasional pulses on events the current state must ignore.
  initial begin
    plan_t      cur;
    int         delay = 0;
    int         pdone = 0;
    logic [2:0] c;
    logic [2:0] prev_cond = 3'b000;
    bit         prev_err = 1'b0;
    cur.op = '0; cur.len = '0; cur.extra = 0; cur.store_delay = 0; cur.stall = 1'b0;
    bus.mc_done = 1'b0; bus.mc_data_done = 1'b0; bus.procc_done = 1'b0; bus.ctrl_error_clr = 1'b0;
    forever begin
      @(negedge ctrl_clk);
      bus.mc_done = 1'b0; bus.mc_data_done = 1'b0; bus.procc_done = 1'b0; bus.ctrl_error_clr = 1'b0;
      c = bus.ctrl_data_condition;
      if (!ctrl_reset_n) begin
        prev_cond = 3'b000;
        prev_err  = 1'b0;
      end else begin
        if (bus.ctrl_error) begin
          if (!prev_err) delay = $urandom_range(0, 4);
          if (delay == 0) bus.ctrl_error_clr = 1'b1;
          else delay--;
        end else begin
          if (c != prev_cond) begin
            if (c == 3'b100) begin
              if (plan_q.size() > 0) cur = plan_q.pop_front();
              pdone = 0;
              delay = cur.store_delay;
            end else begin
              delay = $urandom_range(0, 4);
            end
          end
          case (c)
            3'b100: begin
              if (!cur.stall) begin
                if (delay == 0) bus.mc_done = 1'b1;
                else delay--;
              end
              if ($urandom_range(0, 9) == 0) begin
                bus.mc_data_done = 1'b1;
                bus.procc_done   = 1'b1;
              end
            end
            3'b010: begin
              if (delay == 0) bus.mc_done = 1'b1;
              else delay--;
              if ($urandom_range(0, 9) == 0) bus.procc_done = 1'b1;
              if ($urandom_range(0, 9) == 0) bus.mc_data_done = 1'b1;
            end
            3'b001: begin
              if (delay == 0) begin
                if (pdone < cur.extra) begin
                  bus.procc_done = 1'b1;
                  pdone++;
                end else begin
                  bus.mc_data_done = 1'b1;
                  bus.procc_done   = 1'($urandom_range(0, 1));
                end
              end else begin
                delay--;
              end
              if ($urandom_range(0, 9) == 0) bus.mc_done = 1'b1;
            end
            default: if ($urandom_range(0, 9) == 0) bus.ctrl_error_clr = 1'b1;
          endcase
        end
        prev_cond = c;
        prev_err  = bus.ctrl_error;
      end
    end
  end

  // Monitor: pops the oldest expected outcome on every job_done pulse or error onset.
  initial begin
    logic [2:0] seq[$];
    logic [2:0] pc = 3'b000;
    logic [2:0] c;
    logic [2:0] want;
    bit         pe = 1'b0;
    exp_t       e;
    int         bad;
    forever begin
      @(negedge ctrl_clk);
      if (!ctrl_reset_n) begin
        pc = 3'b000;
        pe = 1'b0;
        seq.delete();
      end else begin
        c = bus.ctrl_data_condition;
        if (c != pc) begin
          if (c == 3'b100) seq.delete();
          seq.push_back(c);
        end
        if (bus.ctrl_job_done) begin
          if (sb_q.size() == 0) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL unexpected_job_done: op %0d, no job expected", bus.procc_instruction);
          end else begin
            e = sb_q.pop_front();
            checkOutput("done_not_error", 32'(bus.ctrl_error), 32'(e.is_err));
            checkOutput("done_op", 32'(bus.procc_instruction), 32'(e.op));
            checkOutput("done_len", 32'(bus.mc_data_length), 32'(e.len));
            checkOutput("done_passes", 32'(bus.ctrl_pass_count), 32'(e.passes));
            checkOutput("cond_seq_len", 32'(seq.size()), 32'(2 + 2 * e.passes));
            bad = 0;
            for (int i = 0; i < seq.size(); i++) begin
              if (i == 0) want = 3'b100;
              else if (i == seq.size() - 1) want = 3'b000;
              else if (i % 2 == 1) want = 3'b010;
              else want = 3'b001;
              if (seq[i] !== want) bad++;
            end
            checkOutput("cond_seq_bad", 32'(bad), 32'd0);
          end
        end
        if (bus.ctrl_error && !pe) begin
          if (sb_q.size() == 0) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL unexpected_error: pass count %0d, no job expected", bus.ctrl_pass_count);
          end else begin
            e = sb_q.pop_front();
            checkOutput("error_expected", 32'(bus.ctrl_job_done), 32'(!e.is_err));
            checkOutput("error_passes", 32'(bus.ctrl_pass_count), 32'(e.passes));
            checkOutput("error_cond", 32'(bus.ctrl_data_condition), 32'd0);
            checkOutput("error_start", 32'(bus.procc_start), 32'd0);
          end
        end
        pc = c;
        pe = bus.ctrl_error;
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(bus.ctrl_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(bus.ctrl_busy), 32'd0);
    checkOutput({tag, "_cond"}, 32'(bus.ctrl_data_condition), 32'd0);
    checkOutput({tag, "_start"}, 32'(bus.procc_start), 32'd0);
    checkOutput({tag, "_error"}, 32'(bus.ctrl_error), 32'd0);
    checkOutput({tag, "_job_done"}, 32'(bus.ctrl_job_done), 32'd0);
    checkOutput({tag, "_passes"}, 32'(bus.ctrl_pass_count), 32'd0);
    checkOutput({tag, "_len"}, 32'(bus.mc_data_length), 32'd0);
    checkOutput({tag, "_op"}, 32'(bus.procc_instruction), 32'd0);
  endtask

  initial begin
    int m;
    int r;
    int g;
    bus.ctrl_instruction  = '0;
    bus.ctrl_data_in_size = '0;
    bus.ctrl_valid_inst   = 1'b0;
    bus.ctrl_valid_data   = 1'b0;

    repeat (3) @(negedge ctrl_clk);
    checkResetOutputs("reset");
    ctrl_reset_n = 1'b1;

    // Single job, then a multi-pass job, then a pass-limit overflow followed by a normal job.
    applyStimulus(5, 12, 0, 2, 1'b0, 1'b0);
    waitDrain(500);
    applyStimulus(3, 40, 3, 1, 1'b0, 1'b0);
    waitDrain(500);
    applyStimulus(6, 7, MAX_PASSES, 0, 1'b0, 1'b0);
    applyStimulus(2, 9, 0, 0, 1'b0, 1'b0);
    waitDrain(1000);

    // FIFO full: first job stalls in STORE while four more arrive back-to-back.
    applyStimulus(1, 1, 0, 15, 1'b0, 1'b0);
    for (int k = 2; k <= 5; k++) applyStimulus(k, k, 0, 0, 1'b0, 1'b0);
    @(negedge ctrl_clk);
    checkOutput("fifo_full_ready", 32'(bus.ctrl_ready), 32'd0);
    checkOutput("fifo_full_store", 32'(bus.ctrl_data_condition), 32'b100);
    applyStimulus(6, 6, 1, 0, 1'b0, 1'b0);
    waitDrain(2000);

    // Watchdog: stalled STORE errors exactly TIMEOUT cycles after entry; queued job resumes.
    applyStimulus(7, 3, 0, 0, 1'b1, 1'b0);
    applyStimulus(4, 5, 1, 0, 1'b0, 1'b0);
    m = -1;
    do begin
      @(negedge ctrl_clk);
      m++;
    end while (!bus.ctrl_error && m < 3 * TIMEOUT);
    checkOutput("timeout_cycles", 32'(m), 32'(TIMEOUT));
    waitDrain(1000);

    // mc_done on the expiry cycle wins over the watchdog.
    applyStimulus(2, 2, 0, TIMEOUT - 1, 1'b0, 1'b0);
    waitDrain(500);

    for (int j = 0; j < 40; j++) begin
      r = $urandom_range(0, 9);
      if (r < 6)
        applyStimulus($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, MAX_PASSES - 1),
                      $urandom_range(0, 6), 1'b0, 1'b1);
      else if (r == 6)
        applyStimulus($urandom_range(0, 7), $urandom_range(0, 63), MAX_PASSES, $urandom_range(0, 6), 1'b0, 1'b1);
      else if (r == 7)
        applyStimulus($urandom_range(0, 7), $urandom_range(0, 63), 0, 0, 1'b1, 1'b1);
      else if (r == 8)
        applyStimulus($urandom_range(0, 7), $urandom_range(0, 63), 0, TIMEOUT - 1, 1'b0, 1'b1);
      else
        applyStimulus($urandom_range(0, 7), $urandom_range(0, 63), 0, 0, 1'b0, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge ctrl_clk);
    end
    waitDrain(10000);
    checkOutput("plans_consumed", 32'(plan_q.size()), 32'd0);

    // Asynchronous reset while PROCESSING with jobs still queued.
    applyStimulus(3, 10, 2, 0, 1'b0, 1'b0);
    applyStimulus(4, 11, 0, 0, 1'b0, 1'b0);
    applyStimulus(5, 12, 0, 0, 1'b0, 1'b0);
    g = 0;
    do begin
      @(negedge ctrl_clk);
      g++;
    end while (bus.ctrl_data_condition != 3'b001 && g < 200);
    checkOutput("reached_processing", 32'(bus.ctrl_data_condition), 32'b001);
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    sb_q.delete();
    plan_q.delete();
    @(negedge ctrl_clk);
    ctrl_reset_n = 1'b1;
    repeat (10) @(negedge ctrl_clk);
    checkOutput("flushed_busy", 32'(bus.ctrl_busy), 32'd0);
    checkOutput("flushed_ready", 32'(bus.ctrl_ready), 32'd1);
    applyStimulus(6, 33, 1, 1, 1'b0, 1'b0);
    waitDrain(500);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
